msi_cache_line_controller: RTL and testbench

- Parametrised successor to the single-line CPU-side MSI state machine.
- Holds a direct-mapped array of 2^INDEX_BITS line states plus tags.
- Accepts CPU read/write requests through a valid/ready handshake and issues bus messages (read miss, write miss, invalidate) under a request/grant handshake.
- Applies snooped bus traffic to its own lines and keeps saturating hit/miss counters.

---
 rtl/msi_cache_line_controller.sv | 193 +++++++++++++++++++
 tb/tb_msi_cache_line_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/msi_cache_line_controller.sv
// ============================================================================
//  Module   : msi_cache_line_controller
//  Purpose  : Direct-mapped MSI line-state array with CPU front end, bus
//             request/grant back end, snoop handling and hit/miss counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module msi_cache_line_controller #(
  parameter int INDEX_BITS  = 2,
  parameter int TAG_BITS    = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cpu_valid,
  input  logic                           cpu_write,
  input  logic [TAG_BITS+INDEX_BITS-1:0] cpu_addr,
  output logic                           cpu_ready,
  output logic                           cpu_done,
  output logic                           cpu_hit,
  output logic                           bus_req,
  output logic [1:0]                     bus_op,
  output logic [TAG_BITS+INDEX_BITS-1:0] bus_addr,
  output logic                           bus_writeback,
  input  logic                           bus_grant,
  input  logic                           snoop_valid,
  input  logic [1:0]                     snoop_op,
  input  logic [TAG_BITS+INDEX_BITS-1:0] snoop_addr,
  output logic                           snoop_flush,
  output logic [COUNT_WIDTH-1:0]         hit_count,
  output logic [COUNT_WIDTH-1:0]         miss_count
);

  localparam int AW    = TAG_BITS + INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  localparam logic [1:0] C_ST_INV  = 2'b00;
  localparam logic [1:0] C_ST_EXCL = 2'b01;
  localparam logic [1:0] C_ST_SHRD = 2'b10;

  localparam logic [1:0] C_OP_RD  = 2'b00;
  localparam logic [1:0] C_OP_WR  = 2'b01;
  localparam logic [1:0] C_OP_INV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_REQ    = 2'd2
  } state_t;

  state_t                 r_fsm;
  logic [1:0]             r_line [LINES];
  logic [TAG_BITS-1:0]    r_tag  [LINES];
  logic                   r_write;
  logic [AW-1:0]          r_addr;
  logic                   r_done;
  logic                   r_hit;
  logic                   r_flush;
  logic [COUNT_WIDTH-1:0] r_hits;
  logic [COUNT_WIDTH-1:0] r_misses;

  logic [INDEX_BITS-1:0]  w_idx;
  logic [TAG_BITS-1:0]    w_tag;
  logic [1:0]             w_cur_state;
  logic [TAG_BITS-1:0]    w_cur_tag;
  logic                   w_match;
  logic [1:0]             w_op;
  logic                   w_grant;

  logic [INDEX_BITS-1:0]  w_snp_idx;
  logic [TAG_BITS-1:0]    w_snp_tag;
  logic [1:0]             w_snp_state;
  logic                   w_snp_match;
  logic [1:0]             w_snp_next;
  logic                   w_snp_flush;

  assign w_idx       = r_addr[INDEX_BITS-1:0];
  assign w_tag       = r_addr[AW-1:INDEX_BITS];
  assign w_cur_state = r_line[w_idx];
  assign w_cur_tag   = r_tag[w_idx];
  assign w_match     = (w_cur_state != C_ST_INV) && (w_cur_tag == w_tag);

  // Derived from the live line state so a snoop during REQ re-shapes the request.
  always_comb begin
    w_op = C_OP_RD;
    if (r_write) begin
      w_op = (w_match && (w_cur_state == C_ST_SHRD)) ? C_OP_INV : C_OP_WR;
    end
  end

  assign w_snp_idx   = snoop_addr[INDEX_BITS-1:0];
  assign w_snp_tag   = snoop_addr[AW-1:INDEX_BITS];
  assign w_snp_state = r_line[w_snp_idx];
  assign w_snp_match = snoop_valid && (w_snp_state != C_ST_INV) && (r_tag[w_snp_idx] == w_snp_tag);

  always_comb begin
    w_snp_next  = w_snp_state;
    w_snp_flush = 1'b0;
    if (w_snp_state == C_ST_EXCL) begin
      if (snoop_op == C_OP_RD) begin
        w_snp_next  = C_ST_SHRD;
        w_snp_flush = 1'b1;
      end else if (snoop_op == C_OP_WR) begin
        w_snp_next  = C_ST_INV;
        w_snp_flush = 1'b1;
      end
    end else if (w_snp_state == C_ST_SHRD) begin
      if ((snoop_op == C_OP_WR) || (snoop_op == C_OP_INV)) begin
        w_snp_next = C_ST_INV;
      end
    end
  end

  // A grant colliding with a snoop is dropped; the request stays pending.
  assign w_grant = (r_fsm == S_REQ) && bus_grant && !snoop_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fsm    <= S_IDLE;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_done   <= 1'b0;
      r_hit    <= 1'b0;
      r_flush  <= 1'b0;
      r_hits   <= '0;
      r_misses <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_line[i] <= C_ST_INV;
        r_tag[i]  <= '0;
      end
    end else begin
      r_done  <= 1'b0;
      r_hit   <= 1'b0;
      r_flush <= w_snp_match && w_snp_flush;

      if (w_snp_match) begin
        r_line[w_snp_idx] <= w_snp_next;
      end else if (w_grant) begin
        r_line[w_idx] <= r_write ? C_ST_EXCL : C_ST_SHRD;
        r_tag[w_idx]  <= w_tag;
      end

      case (r_fsm)
        S_IDLE: begin
          if (cpu_valid) begin
            r_write <= cpu_write;
            r_addr  <= cpu_addr;
            r_fsm   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!snoop_valid) begin
            if (w_match && (!r_write || (w_cur_state == C_ST_EXCL))) begin
              r_done <= 1'b1;
              r_hit  <= 1'b1;
              r_fsm  <= S_IDLE;
              if (r_hits != '1) r_hits <= r_hits + 1'b1;
            end else if (w_match) begin
              r_fsm <= S_REQ;
              if (r_hits != '1) r_hits <= r_hits + 1'b1;
            end else begin
              r_fsm <= S_REQ;
              if (r_misses != '1) r_misses <= r_misses + 1'b1;
            end
          end
        end
        S_REQ: begin
          if (w_grant) begin
            r_done <= 1'b1;
            r_hit  <= (w_op == C_OP_INV);
            r_fsm  <= S_IDLE;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign cpu_ready     = !reset && (r_fsm == S_IDLE);
  assign cpu_done      = r_done;
  assign cpu_hit       = r_hit;
  assign bus_req       = (r_fsm == S_REQ);
  assign bus_op        = bus_req ? w_op : C_OP_RD;
  assign bus_addr      = bus_req ? r_addr : '0;
  assign bus_writeback = bus_req && (w_cur_state == C_ST_EXCL) && (w_cur_tag != w_tag);
  assign snoop_flush   = r_flush;
  assign hit_count     = r_hits;
  assign miss_count    = r_misses;

endmodule

`default_nettype wire

// File: tb/tb_msi_cache_line_controller.sv
// ============================================================================
//  Module   : tb_msi_cache_line_controller
//  Purpose  : Directed vector bench for msi_cache_line_controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_msi_cache_line_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_valid = 1'b0;
  logic       cpu_write = 1'b0;
  logic [5:0] cpu_addr = '0;
  logic       cpu_ready, cpu_done, cpu_hit;
  logic       bus_req, bus_writeback;
  logic [1:0] bus_op;
  logic [5:0] bus_addr;
  logic       bus_grant = 1'b0;
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_op = '0;
  logic [5:0] snoop_addr = '0;
  logic       snoop_flush;
  logic [7:0] hit_count, miss_count;

  int tests = 0;
  int failed = 0;

  msi_cache_line_controller #(
    .INDEX_BITS(2), .TAG_BITS(4), .COUNT_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit),
    .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_writeback(bus_writeback), .bus_grant(bus_grant),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .snoop_flush(snoop_flush), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  // kind 0: CPU access; kind 1: snoop (flag = expected snoop_flush)
  typedef struct {
    logic       kind;
    logic       wr;
    logic [1:0] sop;
    logic [5:0] addr;
    int         gd;
    logic       miss;
    logic [1:0] op;
    logic       wb;
    logic       flag;
    int         hits;
    int         misses;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string t);
    if (!v.kind) begin
      check({t, " ready"}, 32'(cpu_ready), 32'd1);
      cpu_valid = 1'b1;
      cpu_write = v.wr;
      cpu_addr  = v.addr;
      @(negedge clock);
      cpu_valid = 1'b0;
      check({t, " lookup done"}, 32'(cpu_done), 32'd0);
      check({t, " lookup req"}, 32'(bus_req), 32'd0);
      @(negedge clock);
      if (!v.miss) begin
        check({t, " hit done"}, 32'(cpu_done), 32'd1);
        check({t, " hit flag"}, 32'(cpu_hit), 32'(v.flag));
        check({t, " hit no req"}, 32'(bus_req), 32'd0);
      end else begin
        check({t, " req done"}, 32'(cpu_done), 32'd0);
        check({t, " bus_req"}, 32'(bus_req), 32'd1);
        check({t, " bus_op"}, 32'(bus_op), 32'(v.op));
        check({t, " bus_addr"}, 32'(bus_addr), 32'(v.addr));
        check({t, " bus_wb"}, 32'(bus_writeback), 32'(v.wb));
        repeat (v.gd) @(negedge clock);
        bus_grant = 1'b1;
        @(negedge clock);
        bus_grant = 1'b0;
        check({t, " grant done"}, 32'(cpu_done), 32'd1);
        check({t, " grant hit"}, 32'(cpu_hit), 32'(v.flag));
      end
      check({t, " hit_count"}, 32'(hit_count), 32'(v.hits));
      check({t, " miss_count"}, 32'(miss_count), 32'(v.misses));
    end else begin
      snoop_valid = 1'b1;
      snoop_op    = v.sop;
      snoop_addr  = v.addr;
      @(negedge clock);
      snoop_valid = 1'b0;
      check({t, " flush"}, 32'(snoop_flush), 32'(v.flag));
      @(negedge clock);
      check({t, " flush end"}, 32'(snoop_flush), 32'd0);
    end
  endtask

  vec_t v;

  initial begin
    //       kind wr   sop    addr   gd miss op     wb   flag hits misses
    vecs[0]  = '{1'b0, 1'b0, 2'b00, 6'h15, 3, 1'b1, 2'b00, 1'b0, 1'b0, 0, 1};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 6'h15, 0, 1'b0, 2'b00, 1'b0, 1'b1, 1, 1};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 6'h15, 1, 1'b1, 2'b11, 1'b0, 1'b1, 2, 1};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 6'h25, 0, 1'b1, 2'b01, 1'b1, 1'b0, 2, 2};
    vecs[4]  = '{1'b0, 1'b1, 2'b00, 6'h25, 0, 1'b0, 2'b00, 1'b0, 1'b1, 3, 2};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 6'h25, 0, 1'b0, 2'b00, 1'b0, 1'b1, 0, 0};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 6'h25, 0, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 2'b01, 6'h35, 0, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 2'b00, 6'h25, 0, 1'b0, 2'b00, 1'b0, 1'b1, 4, 2};
    vecs[9]  = '{1'b1, 1'b0, 2'b11, 6'h25, 0, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 6'h25, 2, 1'b1, 2'b00, 1'b0, 1'b0, 4, 3};
    vecs[11] = '{1'b0, 1'b0, 2'b00, 6'h0A, 0, 1'b1, 2'b00, 1'b0, 1'b0, 4, 4};

    @(negedge clock);
    check("rst ready", 32'(cpu_ready), 32'd0);
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst bus_op", 32'(bus_op), 32'd0);
    check("rst bus_addr", 32'(bus_addr), 32'd0);
    check("rst wb", 32'(bus_writeback), 32'd0);
    check("rst done", 32'(cpu_done), 32'd0);
    check("rst flush", 32'(snoop_flush), 32'd0);
    check("rst hits", 32'(hit_count), 32'd0);
    check("rst misses", 32'(miss_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Upgrade request downgraded to a write miss by a snoop while pending
    cpu_valid = 1'b1; cpu_write = 1'b1; cpu_addr = 6'h0A;
    @(negedge clock);
    cpu_valid = 1'b0;
    @(negedge clock);
    check("upg op", 32'(bus_op), 32'd3);
    snoop_valid = 1'b1; snoop_op = 2'b01; snoop_addr = 6'h0A;
    @(negedge clock);
    snoop_valid = 1'b0;
    check("upg req held", 32'(bus_req), 32'd1);
    check("upg op after snoop", 32'(bus_op), 32'd1);
    check("upg no flush", 32'(snoop_flush), 32'd0);
    bus_grant = 1'b1;
    @(negedge clock);
    bus_grant = 1'b0;
    check("upg done", 32'(cpu_done), 32'd1);
    check("upg hit", 32'(cpu_hit), 32'd0);
    check("upg hits", 32'(hit_count), 32'd5);
    v = '{1'b0, 1'b1, 2'b00, 6'h0A, 0, 1'b0, 2'b00, 1'b0, 1'b1, 6, 4};
    run_vec(v, "line2 excl");

    // Snoop during LOOKUP stalls one cycle; re-evaluation sees the invalidated line
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 6'h25;
    @(negedge clock);
    cpu_valid = 1'b0;
    snoop_valid = 1'b1; snoop_op = 2'b11; snoop_addr = 6'h25;
    @(negedge clock);
    snoop_valid = 1'b0;
    check("stall done", 32'(cpu_done), 32'd0);
    check("stall req", 32'(bus_req), 32'd0);
    @(negedge clock);
    check("stall bus_req", 32'(bus_req), 32'd1);
    check("stall op", 32'(bus_op), 32'd0);
    bus_grant = 1'b1;
    @(negedge clock);
    bus_grant = 1'b0;
    check("stall cpu_done", 32'(cpu_done), 32'd1);
    check("stall hit", 32'(cpu_hit), 32'd0);
    check("stall hits", 32'(hit_count), 32'd6);
    check("stall misses", 32'(miss_count), 32'd5);

    // Grant with a simultaneous snoop is ignored; then reset mid-REQ
    cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 6'h31;
    @(negedge clock);
    cpu_valid = 1'b0;
    @(negedge clock);
    check("coll req", 32'(bus_req), 32'd1);
    check("coll misses", 32'(miss_count), 32'd6);
    bus_grant = 1'b1; snoop_valid = 1'b1; snoop_op = 2'b00; snoop_addr = 6'h00;
    @(negedge clock);
    bus_grant = 1'b0; snoop_valid = 1'b0;
    check("coll req held", 32'(bus_req), 32'd1);
    check("coll no done", 32'(cpu_done), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("mid rst req", 32'(bus_req), 32'd0);
    check("mid rst done", 32'(cpu_done), 32'd0);
    check("mid rst ready", 32'(cpu_ready), 32'd0);
    check("mid rst hits", 32'(hit_count), 32'd0);
    check("mid rst misses", 32'(miss_count), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post rst done", 32'(cpu_done), 32'd0);
    v = '{1'b0, 1'b0, 2'b00, 6'h25, 0, 1'b1, 2'b00, 1'b0, 1'b0, 0, 1};
    run_vec(v, "post rst miss");

    // Saturation of the hit counter
    for (int i = 1; i <= 300; i++) begin
      v = '{1'b0, 1'b0, 2'b00, 6'h25, 0, 1'b0, 2'b00, 1'b0, 1'b1, (i > 255) ? 255 : i, 1};
      run_vec(v, $sformatf("sat%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
